pru_draw_scheduler: RTL and testbench

- Shares the single PRU preprocessor write port between NREQ draw-command requesters (CPU bridge, sprite engine, etc.).
- Each command is two 32-bit words: word0 carries row, col, colour and shape; word1 carries height/radius, width, subtract and colour_load.
- Arbitrates round-robin, issues the two words as back-to-back write beats, then waits for the PRU draw-done before granting the next command.
- Sits between the requesters and the preprocessor write/data/ack interface.

---
 rtl/pru_draw_scheduler_pkg.sv | 39 +++
 rtl/pru_draw_scheduler_if.sv | 27 ++
 rtl/pru_draw_scheduler_rr_arbiter.sv | 33 +++
 rtl/pru_draw_scheduler.sv | 135 +++++++++++++
 tb/tb_pru_draw_scheduler.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/pru_draw_scheduler_pkg.sv
// Shared types and draw-command word layout for the PRU draw scheduler.
package pru_pkg;

    // Scheduler FSM states (two-bit legacy encoding).
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND0     = 2'd1,
        S_SEND1     = 2'd2,
        S_WAIT_DONE = 2'd3
    } sched_state_t;

    // Word0 field positions.
    localparam int W0_ROW_HI   = 8;
    localparam int W0_ROW_LO   = 0;
    localparam int W0_COL_HI   = 18;
    localparam int W0_COL_LO   = 9;
    localparam int W0_COLOR_HI = 20;
    localparam int W0_COLOR_LO = 19;
    localparam int W0_SHAPE_HI = 22;
    localparam int W0_SHAPE_LO = 21;

    // Word1 field positions.
    localparam int W1_HR_HI    = 8;
    localparam int W1_HR_LO    = 0;
    localparam int W1_WIDTH_HI = 18;
    localparam int W1_WIDTH_LO = 9;
    localparam int W1_SUB      = 21;
    localparam int W1_CLOAD    = 22;

    // Shape codes carried in word0.
    localparam logic [1:0] SHAPE_RECT = 2'b00;
    localparam logic [1:0] SHAPE_CIRC = 2'b01;

    // Extract the shape code from a word0 value.
    function automatic logic [1:0] w0_shape(input logic [31:0] w0);
        return w0[W0_SHAPE_HI:W0_SHAPE_LO];
    endfunction

endpackage

// File: rtl/pru_draw_scheduler_if.sv
// Requester / preprocessor signal bundle around the draw scheduler.
interface pru_draw_scheduler_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]      req;
    logic [32*NREQ-1:0]   cmd_w0;
    logic [32*NREQ-1:0]   cmd_w1;
    logic [NREQ-1:0]      grant;
    logic                 busy;
    logic                 pp_write;
    logic [31:0]          pp_data;
    logic                 pp_ack;
    logic                 pru_done;
    logic                 timeout_err;

    // Scheduler-side view.
    modport master (
        input  req, cmd_w0, cmd_w1, pp_ack, pru_done,
        output grant, busy, pp_write, pp_data, timeout_err
    );

    // Environment-side view (requesters, preprocessor, PRU).
    modport slave (
        output req, cmd_w0, cmd_w1, pp_ack, pru_done,
        input  grant, busy, pp_write, pp_data, timeout_err
    );
endinterface

// File: rtl/pru_draw_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request above last_grant, wrapping.
module pru_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int LGW  = 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [LGW-1:0]  i_last_grant,
    output logic [NREQ-1:0] o_grant,
    output logic [LGW-1:0]  o_idx,
    output logic            o_valid
);

    logic [LGW-1:0] w_pos;

    // Scan NREQ positions starting just after the previous winner.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_pos = LGW'((int'(i_last_grant) + k) % NREQ);
            if (!o_valid && i_req[w_pos]) begin
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
                o_valid        = 1'b1;
            end else begin
                o_valid = o_valid;
            end
        end
    end

endmodule

// File: rtl/pru_draw_scheduler.sv
// Shares the PRU preprocessor write port between NREQ draw-command requesters.
module pru_draw_scheduler #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    pru_draw_scheduler_if.master  bus
);
    import pru_pkg::*;

    localparam int LGW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]  T_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [TW-1:0]  T_SAT  = {TW{1'b1}};

    localparam logic [1:0] ST_IDLE      = S_IDLE;
    localparam logic [1:0] ST_SEND0     = S_SEND0;
    localparam logic [1:0] ST_SEND1     = S_SEND1;
    localparam logic [1:0] ST_WAIT_DONE = S_WAIT_DONE;

    logic [1:0]       r_state;
    logic [LGW-1:0]   r_last_grant;
    logic [31:0]      r_word1;
    logic [TW-1:0]    r_timer;
    logic [NREQ-1:0]  r_grant;
    logic             r_busy;
    logic             r_pp_write;
    logic [31:0]      r_pp_data;
    logic             r_timeout_err;

    logic [NREQ-1:0]  w_arb_grant;
    logic [LGW-1:0]   w_arb_idx;
    logic             w_arb_valid;
    logic [31:0]      w_sel_w0;
    logic [31:0]      w_sel_w1;

    pru_rr_arbiter #(
        .NREQ (NREQ),
        .LGW  (LGW)
    ) u_arb (
        .i_req        (bus.req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_arb_grant),
        .o_idx        (w_arb_idx),
        .o_valid      (w_arb_valid)
    );

    // One-hot mux of the winning requester's command words.
    always_comb begin
        w_sel_w0 = 32'h0000_0000;
        w_sel_w1 = 32'h0000_0000;
        for (int i = 0; i < NREQ; i++) begin
            w_sel_w0 = w_sel_w0 | (bus.cmd_w0[32*i +: 32] & {32{w_arb_grant[i]}});
            w_sel_w1 = w_sel_w1 | (bus.cmd_w1[32*i +: 32] & {32{w_arb_grant[i]}});
        end
    end

    // Scheduler FSM; every output is a register updated with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= LGW'(NREQ - 1);
            r_word1       <= 32'h0000_0000;
            r_timer       <= '0;
            r_grant       <= '0;
            r_busy        <= 1'b0;
            r_pp_write    <= 1'b0;
            r_pp_data     <= 32'h0000_0000;
            r_timeout_err <= 1'b0;
        end else begin
            r_grant       <= '0;
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_state      <= ST_SEND0;
                        r_grant      <= w_arb_grant;
                        r_last_grant <= w_arb_idx;
                        r_word1      <= w_sel_w1;
                        r_pp_data    <= w_sel_w0;
                        r_pp_write   <= 1'b1;
                        r_busy       <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SEND0: begin
                    if (bus.pp_ack) begin
                        r_state   <= ST_SEND1;
                        r_pp_data <= r_word1;
                    end else begin
                        r_state <= ST_SEND0;
                    end
                end
                ST_SEND1: begin
                    if (bus.pp_ack) begin
                        r_state    <= ST_WAIT_DONE;
                        r_pp_write <= 1'b0;
                        r_timer    <= '0;
                    end else begin
                        r_state <= ST_SEND1;
                    end
                end
                ST_WAIT_DONE: begin
                    // A done arriving on the expiry cycle takes precedence.
                    if (bus.pru_done) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if ((TIMEOUT != 0) && (r_timer == T_LAST)) begin
                        r_state       <= ST_IDLE;
                        r_busy        <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end else if (r_timer != T_SAT) begin
                        r_timer <= r_timer + 1'b1;
                    end else begin
                        r_timer <= r_timer;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_pp_write <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant       = r_grant;
    assign bus.busy        = r_busy;
    assign bus.pp_write    = r_pp_write;
    assign bus.pp_data     = r_pp_data;
    assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_pru_draw_scheduler.sv
// Self-checking bench for pru_draw_scheduler (NREQ=2, TIMEOUT=16).
module tb_pru_draw_scheduler;

    logic clk;
    logic rst;
    logic ack_en;
    int   total;
    int   bad;
    int   last;   // model: index of the most recent winner

    pru_draw_scheduler_if #(.NREQ(2)) bus ();

    assign bus.pp_ack = bus.pp_write & ack_en;

    pru_draw_scheduler #(.NREQ(2), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rq;
        logic [31:0] a0, a1, b0, b1;
        int          stall;
        int          stale;
        int          dly;
        logic [1:0]  eg;
        logic [31:0] e0, e1;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one command and follow it to the first WAIT_DONE cycle.
    task automatic issue(input logic [1:0] rq, input logic [63:0] c0, input logic [63:0] c1,
                         input int stall, input int stale,
                         input logic [1:0] eg, input logic [31:0] e0, input logic [31:0] e1);
        bus.req    = rq;
        bus.cmd_w0 = c0;
        bus.cmd_w1 = c1;
        ack_en     = (stall == 0);
        tick();
        check("grant", 64'(bus.grant), 64'(eg));
        check("w0_write", 64'(bus.pp_write), 64'd1);
        check("w0_data", 64'(bus.pp_data), 64'(e0));
        check("send_busy", 64'(bus.busy), 64'd1);
        bus.req      = 2'b00;
        bus.cmd_w0   = ~c0;
        bus.cmd_w1   = ~c1;
        bus.pru_done = (stale != 0);
        for (int s = 1; s < stall; s++) begin
            tick();
            bus.pru_done = 1'b0;
            check("stall_write", 64'(bus.pp_write), 64'd1);
            check("stall_data", 64'(bus.pp_data), 64'(e0));
            check("stall_grant", 64'(bus.grant), 64'd0);
        end
        ack_en = 1'b1;
        tick();
        bus.pru_done = 1'b0;
        check("w1_write", 64'(bus.pp_write), 64'd1);
        check("w1_data", 64'(bus.pp_data), 64'(e1));
        check("w1_grant", 64'(bus.grant), 64'd0);
        tick();
        check("wait_write", 64'(bus.pp_write), 64'd0);
        check("wait_busy", 64'(bus.busy), 64'd1);
        check("wait_data", 64'(bus.pp_data), 64'(e1));
    endtask

    // Stay dly extra cycles in WAIT_DONE, then pulse pru_done.
    task automatic finish_done(input int dly);
        for (int i = 0; i < dly; i++) begin
            tick();
            check("wait_busy2", 64'(bus.busy), 64'd1);
            check("wait_no_to", 64'(bus.timeout_err), 64'd0);
        end
        bus.pru_done = 1'b1;
        tick();
        bus.pru_done = 1'b0;
        check("done_idle", 64'(bus.busy), 64'd0);
        check("done_no_to", 64'(bus.timeout_err), 64'd0);
        check("idle_write", 64'(bus.pp_write), 64'd0);
    endtask

    // Reference round-robin choice: first requester after the last winner.
    function automatic int pick(input logic [1:0] rq, input int lst);
        for (int k = 1; k <= 2; k++) begin
            if (rq[(lst + k) % 2]) return (lst + k) % 2;
        end
        return -1;
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        ack_en       = 1'b1;
        bus.req      = 2'b00;
        bus.cmd_w0   = 64'd0;
        bus.cmd_w1   = 64'd0;
        bus.pru_done = 1'b0;

        tbl[0] = '{2'b01, 32'h0028_1464, 32'h0000_A032, 32'hDEAD_0001, 32'hDEAD_0002, 0, 0, 7,  2'b01, 32'h0028_1464, 32'h0000_A032};
        tbl[1] = '{2'b11, 32'h1111_0001, 32'h1111_0002, 32'h2222_0001, 32'h2222_0002, 0, 0, 3,  2'b10, 32'h2222_0001, 32'h2222_0002};
        tbl[2] = '{2'b11, 32'h1111_0003, 32'h1111_0004, 32'h2222_0003, 32'h2222_0004, 0, 0, 3,  2'b01, 32'h1111_0003, 32'h1111_0004};
        tbl[3] = '{2'b11, 32'h1111_0005, 32'h1111_0006, 32'h2222_0005, 32'h2222_0006, 0, 0, 3,  2'b10, 32'h2222_0005, 32'h2222_0006};
        tbl[4] = '{2'b11, 32'h1111_0007, 32'h1111_0008, 32'h2222_0007, 32'h2222_0008, 0, 0, 3,  2'b01, 32'h1111_0007, 32'h1111_0008};
        tbl[5] = '{2'b10, 32'h3333_0001, 32'h3333_0002, 32'h4444_0001, 32'h4444_0002, 5, 0, 2,  2'b10, 32'h4444_0001, 32'h4444_0002};
        tbl[6] = '{2'b01, 32'h0123_4567, 32'h89AB_CDEF, 32'h5555_0001, 32'h5555_0002, 0, 1, 4,  2'b01, 32'h0123_4567, 32'h89AB_CDEF};
        tbl[7] = '{2'b11, 32'h6666_0001, 32'h6666_0002, 32'h7777_0001, 32'h7777_0002, 0, 0, 15, 2'b10, 32'h7777_0001, 32'h7777_0002};

        // Reset state.
        @(negedge clk);
        tick();
        tick();
        check("rst_grant", 64'(bus.grant), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_write", 64'(bus.pp_write), 64'd0);
        check("rst_data", 64'(bus.pp_data), 64'd0);
        check("rst_to", 64'(bus.timeout_err), 64'd0);
        rst = 1'b0;

        // Directed vector table.
        for (int v = 0; v < 8; v++) begin
            issue(tbl[v].rq, {tbl[v].b0, tbl[v].a0}, {tbl[v].b1, tbl[v].a1},
                  tbl[v].stall, tbl[v].stale, tbl[v].eg, tbl[v].e0, tbl[v].e1);
            finish_done(tbl[v].dly);
        end

        // Timeout: no pru_done; timeout_err 16 edges after the word1 ack.
        issue(2'b01, {32'hAAAA_0001, 32'hBBBB_0001}, {32'hAAAA_0002, 32'hBBBB_0002},
              0, 0, 2'b01, 32'hBBBB_0001, 32'hBBBB_0002);
        begin
            int n;
            n = 0;
            while (bus.timeout_err !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            check("timeout_cycles", 64'(n), 64'd16);
            check("timeout_busy", 64'(bus.busy), 64'd0);
            tick();
            check("timeout_pulse", 64'(bus.timeout_err), 64'd0);
        end
        issue(2'b11, {32'hCCCC_0001, 32'hDDDD_0001}, {32'hCCCC_0002, 32'hDDDD_0002},
              0, 0, 2'b10, 32'hCCCC_0001, 32'hCCCC_0002);
        finish_done(2);

        // Reset during SEND1.
        bus.req    = 2'b01;
        bus.cmd_w0 = {32'h0, 32'hEEEE_0001};
        bus.cmd_w1 = {32'h0, 32'hEEEE_0002};
        ack_en     = 1'b1;
        tick();
        check("mid_grant", 64'(bus.grant), 64'd1);
        bus.req = 2'b00;
        tick();
        ack_en  = 1'b0;
        check("mid_send1", 64'(bus.pp_data), 64'h0000_0000_EEEE_0002);
        rst = 1'b1;
        tick();
        check("mid_rst_write", 64'(bus.pp_write), 64'd0);
        check("mid_rst_grant", 64'(bus.grant), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        rst    = 1'b0;
        ack_en = 1'b1;
        issue(2'b11, {32'hF0F0_0001, 32'h0F0F_0001}, {32'hF0F0_0002, 32'h0F0F_0002},
              0, 0, 2'b01, 32'h0F0F_0001, 32'h0F0F_0002);
        finish_done(1);
        last = 0;

        // Randomized commands against the reference model.
        for (int r = 0; r < 24; r++) begin
            logic [1:0]  rq;
            logic [63:0] c0, c1;
            int          w;
            rq = 2'($urandom_range(1, 3));
            c0 = {$urandom, $urandom};
            c1 = {$urandom, $urandom};
            w  = pick(rq, last);
            last = w;
            issue(rq, c0, c1, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                  2'(2'b01 << w),
                  (w == 1) ? c0[63:32] : c0[31:0],
                  (w == 1) ? c1[63:32] : c1[31:0]);
            finish_done(int'($urandom_range(0, 14)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
